feature_collector: RTL and testbench

//  Sink end of the per-pixel feature stream (detected/strength/descriptor/x/y) produced by the

---
 rtl/feature_collector.sv | 156 +++++++++++++++
 tb/tb_feature_collector.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_collector.sv
// feature_collector: captures qualified features of the active frame into a
// first-word fall-through FIFO and reports per-frame count/overflow.
// Optional: define FEATURE_COLLECTOR_DROP_CNT_EN to add the drop_count output.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   frame_start_in, frame_end_in   frame delimiters (1-cycle pulses)
//   detected_in + feature fields   incoming pixel beat
//   out_valid/out_ready + out_*    FIFO head, valid/ready handshake
//   frame_done                     pulse after an accepted frame end
//   frame_count, frame_overflow    results of last completed frame (held)
//   drop_count                     rejected pushes in last frame (optional)
module feature_collector #(
    parameter int BW    = 8,
    parameter int DW    = 128,
    parameter int IND_W = 10,
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start_in,
    input  logic             frame_end_in,
    input  logic             detected_in,
    input  logic [BW-1:0]    strength_in,
    input  logic [DW-1:0]    descriptor_in,
    input  logic [IND_W-1:0] x_in,
    input  logic [IND_W-1:0] y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BW-1:0]    out_strength,
    output logic [DW-1:0]    out_descriptor,
    output logic [IND_W-1:0] out_x,
    output logic [IND_W-1:0] out_y,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count,
    output logic             frame_overflow
`ifdef FEATURE_COLLECTOR_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0] drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = BW + DW + 2 * IND_W;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [AW:0]      wr_q, rd_q;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    head;
    logic [CNT_W-1:0] run_q, run_nx;
    logic [CNT_W-1:0] fc_q;
    logic             drop_q, drop_nx, fo_q, done_q;
    logic             active, end_acc, clr;
    logic             empty, full, pop, push_req, push, drop;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: in ACTIVE an end beat wins over a same-cycle start
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (frame_start_in) state_d = ACTIVE;
            ACTIVE: if (frame_end_in)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM-derived controls
    always_comb begin
        active  = (state_q == ACTIVE);
        end_acc = active & frame_end_in;
        clr     = frame_start_in & ~end_acc;
    end

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // A full FIFO still accepts a push when the head leaves this cycle
    assign pop      = ~empty & out_ready;
    assign push_req = active & detected_in;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & ~push;

    assign run_nx  = (push && run_q != '1) ? run_q + 1'b1 : run_q;
    assign drop_nx = drop_q | drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            run_q  <= '0;
            drop_q <= 1'b0;
            fc_q   <= '0;
            fo_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            done_q <= end_acc;
            if (clr) begin
                run_q  <= '0;
                drop_q <= 1'b0;
            end else begin
                run_q  <= run_nx;
                drop_q <= drop_nx;
            end
            if (end_acc) begin
                fc_q <= run_nx;
                fo_q <= drop_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q[AW-1:0]] <= {strength_in, descriptor_in, x_in, y_in};
    end

    // Head is masked so the data outputs read zero whenever nothing is queued
    assign head           = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign out_valid      = ~empty;
    assign out_strength   = head[EW-1 -: BW];
    assign out_descriptor = head[2*IND_W +: DW];
    assign out_x          = head[IND_W +: IND_W];
    assign out_y          = head[0 +: IND_W];
    assign frame_done     = done_q;
    assign frame_count    = fc_q;
    assign frame_overflow = fo_q;

`ifdef FEATURE_COLLECTOR_DROP_CNT_EN
    logic [CNT_W-1:0] dcnt_q, dcnt_nx, dc_q;

    assign dcnt_nx = (drop && dcnt_q != '1) ? dcnt_q + 1'b1 : dcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q <= '0;
            dc_q   <= '0;
        end else begin
            if (clr) dcnt_q <= '0;
            else     dcnt_q <= dcnt_nx;
            if (end_acc) dc_q <= dcnt_nx;
        end
    end

    assign drop_count = dc_q;
`endif

endmodule

// File: tb/tb_feature_collector.sv
// tb_feature_collector: vector table, directed corner sequences and random
// traffic checked against a queue-based model of the feature collector.
module tb_feature_collector;

    localparam int BW    = 8;
    localparam int DW    = 128;
    localparam int IND_W = 10;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             frame_start_in, frame_end_in, detected_in;
    logic [BW-1:0]    strength_in;
    logic [DW-1:0]    descriptor_in;
    logic [IND_W-1:0] x_in, y_in;
    logic             out_valid, out_ready;
    logic [BW-1:0]    out_strength;
    logic [DW-1:0]    out_descriptor;
    logic [IND_W-1:0] out_x, out_y;
    logic             frame_done;
    logic [CNT_W-1:0] frame_count;
    logic             frame_overflow;
`ifdef FEATURE_COLLECTOR_DROP_CNT_EN
    logic [CNT_W-1:0] drop_count;
`endif

    feature_collector #(
        .BW(BW), .DW(DW), .IND_W(IND_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .frame_start_in(frame_start_in), .frame_end_in(frame_end_in),
        .detected_in(detected_in), .strength_in(strength_in),
        .descriptor_in(descriptor_in), .x_in(x_in), .y_in(y_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_strength(out_strength), .out_descriptor(out_descriptor),
        .out_x(out_x), .out_y(out_y), .frame_done(frame_done),
        .frame_count(frame_count), .frame_overflow(frame_overflow)
`ifdef FEATURE_COLLECTOR_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0]    s;
        logic [DW-1:0]    d;
        logic [IND_W-1:0] x;
        logic [IND_W-1:0] y;
    } feat_t;

    typedef struct {
        bit st, en, det, rdy;
        int x, y;
        bit e_valid;
        int e_x, e_y;
        bit e_done;
        int e_cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    feat_t q[$];
    bit    m_active;
    int    m_run, m_drops, m_fc, m_dc;
    bit    m_drop, m_fo, m_done;

    function automatic void chk(string n, logic [127:0] a, logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_active = 0; m_run = 0; m_drops = 0; m_fc = 0; m_dc = 0;
        m_drop = 0; m_fo = 0; m_done = 0;
    endfunction

    function automatic void compare();
        int maxc = (1 << CNT_W) - 1;
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_strength", out_strength, q[0].s);
            chk("out_descriptor", out_descriptor, q[0].d);
            chk("out_x", out_x, q[0].x);
            chk("out_y", out_y, q[0].y);
        end else begin
            chk("out_data_zero",
                {out_strength, out_descriptor, out_x, out_y}, '0);
        end
        chk("frame_done", frame_done, m_done);
        chk("frame_count", frame_count, (m_fc > maxc) ? maxc : m_fc);
        chk("frame_overflow", frame_overflow, m_fo);
`ifdef FEATURE_COLLECTOR_DROP_CNT_EN
        chk("drop_count", drop_count, (m_dc > maxc) ? maxc : m_dc);
`endif
    endfunction

    // Applies the rules to the inputs currently driven
    function automatic void model_step();
        feat_t f;
        bit pop, endacc, room;
        pop    = (q.size() > 0) && out_ready;
        endacc = m_active && frame_end_in;
        room   = (q.size() < DEPTH) || pop;
        if (pop) void'(q.pop_front());
        if (m_active && detected_in) begin
            if (room) begin
                f.s = strength_in; f.d = descriptor_in;
                f.x = x_in; f.y = y_in;
                q.push_back(f);
                m_run++;
            end else begin
                m_drop = 1;
                m_drops++;
            end
        end
        m_done = endacc;
        if (endacc) begin
            m_fc = m_run; m_fo = m_drop; m_dc = m_drops;
            m_active = 0;
        end else if (frame_start_in) begin
            m_active = 1; m_run = 0; m_drop = 0; m_drops = 0;
        end
    endfunction

    task automatic cycle();
        @(negedge clk);
        compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit st, en, det, rdy);
        frame_start_in = st;
        frame_end_in   = en;
        detected_in    = det;
        out_ready      = rdy;
        strength_in    = BW'($urandom);
        descriptor_in  = {$urandom, $urandom, $urandom, $urandom};
        x_in           = IND_W'($urandom);
        y_in           = IND_W'($urandom);
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_count", frame_count, '0);
        chk("rst_ovf", frame_overflow, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vt[6];
    int   pops;

    initial begin
        rst_n = 1'b0;
        frame_start_in = 0; frame_end_in = 0; detected_in = 0;
        out_ready = 0; strength_in = 0; descriptor_in = 0;
        x_in = 0; y_in = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_data", {out_strength, out_descriptor, out_x, out_y}, '0);
        chk("reset_done", frame_done, 1'b0);
        chk("reset_count", frame_count, '0);
        chk("reset_ovf", frame_overflow, 1'b0);
        rst_n = 1'b1;

        // Test 1: vector table, expected values after each edge
        vt[0] = '{1,0,0,0,  0,0, 0, 0,0, 0,0};
        vt[1] = '{0,0,1,0,  5,7, 1, 5,7, 0,0};
        vt[2] = '{0,0,1,0, 12,9, 1, 5,7, 0,0};
        vt[3] = '{0,1,0,0,  0,0, 1, 5,7, 1,2};
        vt[4] = '{0,0,0,1,  0,0, 1,12,9, 0,2};
        vt[5] = '{0,0,0,1,  0,0, 0, 0,0, 0,2};
        for (int i = 0; i < 6; i++) begin
            frame_start_in = vt[i].st;
            frame_end_in   = vt[i].en;
            detected_in    = vt[i].det;
            out_ready      = vt[i].rdy;
            x_in = IND_W'(vt[i].x);
            y_in = IND_W'(vt[i].y);
            @(posedge clk);
            #1;
            chk($sformatf("t1_valid[%0d]", i), out_valid, vt[i].e_valid);
            chk($sformatf("t1_x[%0d]", i), out_x, vt[i].e_x);
            chk($sformatf("t1_y[%0d]", i), out_y, vt[i].e_y);
            chk($sformatf("t1_done[%0d]", i), frame_done, vt[i].e_done);
            chk($sformatf("t1_cnt[%0d]", i), frame_count, vt[i].e_cnt);
            chk($sformatf("t1_ovf[%0d]", i), frame_overflow, 1'b0);
        end
        do_reset();

        // Test 2: overflow with reader stalled
        drive(1, 0, 0, 0);
        repeat (6) drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        chk("t2_done", frame_done, 1'b1);
        chk("t2_count", frame_count, 4);
        chk("t2_ovf", frame_overflow, 1'b1);
`ifdef FEATURE_COLLECTOR_DROP_CNT_EN
        chk("t2_drops", drop_count, 2);
`endif
        drive(0, 0, 0, 0);
        chk("t2_done_pulse", frame_done, 1'b0);
        repeat (5) drive(0, 0, 0, 1);

        // Test 3: push into full FIFO while head is popped
        drive(1, 0, 0, 0);
        repeat (4) drive(0, 0, 1, 0);
        drive(0, 0, 1, 1);
        chk("t3_valid", out_valid, 1'b1);
        drive(0, 1, 0, 0);
        chk("t3_count", frame_count, 5);
        chk("t3_ovf", frame_overflow, 1'b0);
        repeat (5) drive(0, 0, 0, 1);

        // Test 4: detections in IDLE are ignored
        repeat (4) begin
            drive(0, 0, 1, 1);
            chk("t4_valid", out_valid, 1'b0);
            chk("t4_done", frame_done, 1'b0);
        end

        // Test 5: restart mid-frame keeps FIFO, resets count
        drive(1, 0, 0, 0);
        repeat (3) drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        chk("t5_count", frame_count, 1);
        chk("t5_ovf", frame_overflow, 1'b0);
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) pops++;
            drive(0, 0, 0, 1);
        end
        chk("t5_delivered", pops, 4);

        // Test 6: reset mid-frame with entries queued
        drive(1, 0, 0, 0);
        repeat (3) drive(0, 0, 1, 0);
        chk("t6_pre_valid", out_valid, 1'b1);
        do_reset();
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        chk("t6_idle_valid", out_valid, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit st, en, det;
            st  = ($urandom_range(99) < 4);
            en  = ($urandom_range(99) < 4);
            det = !st && ($urandom_range(99) < 55);
            drive(st, en, det, $urandom_range(99) < 50);
        end
        drive(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
